reg_file_mp: RTL and testbench

//  Parametrised CPU register file: two async read ports, one sync write port, hardwired-zero reg 0.

---
 rtl/reg_file_pkg.sv | 14 +
 rtl/reg_file_clr_fsm.sv | 55 +++++
 rtl/reg_file_mp.sv | 76 +++++++
 tb/tb_reg_file_mp.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared FSM encoding and counter sizing for reg_file_mp
package reg_file_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  // One spare bit above the index width so the last-register compare cannot alias on wrap.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/reg_file_clr_fsm.sv
// rtl/reg_file_clr_fsm.sv - bulk-clear sequencer: sweeps every implemented register to zero
module reg_file_clr_fsm
  import reg_file_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam int              CNT_W = cnt_width(DEPTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

  clr_state_t       state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      clr_busy <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clr_req) begin
            state    <= ST_CLEAR;
            cnt      <= '0;
            clr_busy <= 1'b1;
          end
        end
        ST_CLEAR: begin
          // A request arriving mid-sweep is deliberately not looked at here.
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            state    <= ST_IDLE;
            clr_busy <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          clr_busy <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we   = (state == ST_CLEAR);
  assign clr_addr = ADDR_W'(cnt);

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - 2R/1W register file with bulk clear; REG_FILE_BYPASS_EN adds write-through reads
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] r_addr_a,
  input  logic [ADDR_W-1:0] r_addr_b,
  output logic [DATA_W-1:0] r_data_a,
  output logic [DATA_W-1:0] r_data_b,
  input  logic              write_reg,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              w_drop
);

  localparam int              IDX_W   = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] regs [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              w_in_range;
  logic              commit;
  logic              drop;

  // Implemented and not the hardwired-zero register.
  function automatic logic is_live(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_X) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  reg_file_clr_fsm #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_clr_fsm (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign w_in_range = ({1'b0, w_addr} < DEPTH_X);
  assign commit     = write_reg && !clr_we && is_live(w_addr);
  assign drop       = write_reg && (clr_we || !w_in_range);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (clr_we) begin
      regs[IDX_W'(clr_addr)] <= '0;
    end else if (commit) begin
      regs[IDX_W'(w_addr)] <= w_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) w_drop <= 1'b0;
    else     w_drop <= drop;
  end

  always_comb begin
    r_data_a = is_live(r_addr_a) ? regs[IDX_W'(r_addr_a)] : '0;
    r_data_b = is_live(r_addr_b) ? regs[IDX_W'(r_addr_b)] : '0;
`ifdef REG_FILE_BYPASS_EN
    if (commit && (r_addr_a == w_addr)) r_data_a = w_data;
    if (commit && (r_addr_b == w_addr)) r_data_b = w_data;
`endif
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - self-checking bench for reg_file_mp (table vectors plus sweep/reset sequences)
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  r_addr_a = '0, r_addr_b = '0, w_addr = '0;
  logic [31:0] r_data_a, r_data_b, w_data = '0;
  logic        write_reg = 1'b0, clr_req = 1'b0, clr_busy, w_drop;

  logic [4:0]  ra16 = '0, wa16 = '0;
  logic [31:0] rd16_a, rd16_b, wd16 = '0;
  logic        we16 = 1'b0, busy16, drop16;

  always #5 clk = ~clk;

  reg_file_mp u_dut (
    .clk(clk), .rst(rst), .r_addr_a(r_addr_a), .r_addr_b(r_addr_b),
    .r_data_a(r_data_a), .r_data_b(r_data_b), .write_reg(write_reg),
    .w_addr(w_addr), .w_data(w_data), .clr_req(clr_req),
    .clr_busy(clr_busy), .w_drop(w_drop)
  );

  reg_file_mp #(.DEPTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .r_addr_a(ra16), .r_addr_b(ra16),
    .r_data_a(rd16_a), .r_data_b(rd16_b), .write_reg(we16),
    .w_addr(wa16), .w_data(wd16), .clr_req(1'b0),
    .clr_busy(busy16), .w_drop(drop16)
  );

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] ea;
    logic [31:0] eb;
    logic        ed;
  } vec_t;
  vec_t tbl[7];

  int n_vec = 0;
  int n_err = 0;

  task automatic push(input string n, input logic [31:0] e);
    sb.push_back('{n, e});
  endtask

  task automatic pop_cmp(input logic [31:0] act);
    sb_t s;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: got %h with nothing expected", act);
    end else begin
      s = sb.pop_front();
      if (act !== s.exp) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", s.name, act, s.exp);
      end
    end
  endtask

  task automatic fill(input int base);
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      write_reg = 1'b1; w_addr = 5'(i); w_data = 32'(base + i);
    end
    @(negedge clk);
    write_reg = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;

    tbl[0] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd31, 32'h0,        32'h0,        1'b0};
    tbl[1] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        1'b0};
    tbl[2] = '{1'b1, 5'd0,  32'h1234,     5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 1'b0};
    tbl[3] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd5,  32'hA5A5A5A5, 32'hDEADBEEF, 1'b0};
    tbl[4] = '{1'b1, 5'd5,  32'h11,       5'd5,  5'd31, 32'h11,       32'hA5A5A5A5, 1'b0};
    tbl[5] = '{1'b0, 5'd5,  32'hFFFFFFFF, 5'd5,  5'd0,  32'h11,       32'h0,        1'b0};
    tbl[6] = '{1'b1, 5'd1,  32'h1,        5'd1,  5'd0,  32'h1,        32'h0,        1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0; r_addr_a = 5'd0; r_addr_b = 5'd31;
    #1;
    push("rst_read_a", 32'h0); push("rst_read_b", 32'h0);
    push("rst_busy", 32'h0);   push("rst_drop", 32'h0);
    pop_cmp(r_data_a); pop_cmp(r_data_b); pop_cmp({31'h0, clr_busy}); pop_cmp({31'h0, w_drop});

    // Table vectors: reads sampled after the edge that commits the row's write
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      write_reg = tbl[i].we; w_addr = tbl[i].wa; w_data = tbl[i].wd;
      r_addr_a = tbl[i].ra;  r_addr_b = tbl[i].rb;
      push($sformatf("tbl%0d_a", i), tbl[i].ea);
      push($sformatf("tbl%0d_b", i), tbl[i].eb);
      push($sformatf("tbl%0d_drop", i), {31'h0, tbl[i].ed});
      @(posedge clk); #1;
      pop_cmp(r_data_a); pop_cmp(r_data_b); pop_cmp({31'h0, w_drop});
    end
    @(negedge clk); write_reg = 1'b0;

    // Same-cycle write and read of reg 7
    @(negedge clk);
    write_reg = 1'b1; w_addr = 5'd7; w_data = 32'hCAFE; r_addr_a = 5'd7;
`ifdef REG_FILE_BYPASS_EN
    push("bypass_same_cycle", 32'hCAFE);
`else
    push("bypass_same_cycle", 32'h0);
`endif
    #1 pop_cmp(r_data_a);
    push("write_after_edge", 32'hCAFE);
    @(posedge clk); #1 pop_cmp(r_data_a);
    @(negedge clk); write_reg = 1'b0;

    // Full sweep: reg 10 survives until its own sweep cycle
    fill(0);
    r_addr_a = 5'd10;
    @(negedge clk); clr_req = 1'b1;
    @(negedge clk); clr_req = 1'b0;
    k = 0;
    while (clr_busy && k < 100) begin
      if (k == 10) begin push("sweep_reg10_before", 32'd10); pop_cmp(r_data_a); end
      if (k == 11) begin push("sweep_reg10_after", 32'd0);   pop_cmp(r_data_a); end
      k++;
      @(negedge clk);
    end
    push("sweep_len", 32'd32); pop_cmp(32'(k));
    for (int i = 0; i < 32; i++) begin
      r_addr_b = 5'(i);
      push($sformatf("swept_reg%0d", i), 32'h0);
      #1 pop_cmp(r_data_b);
    end

    // Sweep started by a same-cycle write; dropped write and ignored re-request mid-sweep
    @(negedge clk);
    write_reg = 1'b1; w_addr = 5'd9; w_data = 32'h99; clr_req = 1'b1; r_addr_a = 5'd9;
    @(negedge clk);
    write_reg = 1'b0; clr_req = 1'b0;
    k = 0;
    while (clr_busy && k < 100) begin
      if (k == 0) begin push("same_cycle_write_kept", 32'h99); pop_cmp(r_data_a); end
      if (k == 5) begin write_reg = 1'b1; w_addr = 5'd3; w_data = 32'h33; end
      if (k == 6) begin
        write_reg = 1'b0;
        push("drop_during_clear", 32'h1); pop_cmp({31'h0, w_drop});
      end
      if (k == 7) begin push("drop_one_cycle", 32'h0); pop_cmp({31'h0, w_drop}); end
      if (k == 8) clr_req = 1'b1;
      if (k == 9) clr_req = 1'b0;
      if (k == 10) begin push("same_cycle_write_swept", 32'h0); pop_cmp(r_data_a); end
      k++;
      @(negedge clk);
    end
    push("sweep_len_rereq", 32'd32); pop_cmp(32'(k));
    r_addr_b = 5'd3;
    push("reg3_after_drop", 32'h0); #1 pop_cmp(r_data_b);
    @(negedge clk);
    push("busy_stays_low", 32'h0); pop_cmp({31'h0, clr_busy});

    // Async reset mid-sweep
    fill(100);
    @(negedge clk); clr_req = 1'b1;
    @(negedge clk); clr_req = 1'b0;
    k = 0;
    while (clr_busy && k < 12) begin k++; @(negedge clk); end
    r_addr_a = 5'd20;
    push("pre_reset_reg20", 32'd120); #1 pop_cmp(r_data_a);
    rst = 1'b1;
    #1;
    push("rst_busy_immediate", 32'h0); pop_cmp({31'h0, clr_busy});
    for (int i = 0; i < 32; i++) begin
      r_addr_b = 5'(i);
      push($sformatf("rst_reg%0d", i), 32'h0);
      #1 pop_cmp(r_data_b);
    end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    push("no_resume_after_rst", 32'h0); pop_cmp({31'h0, clr_busy});

    // DEPTH=16 instance: unimplemented address
    @(negedge clk);
    we16 = 1'b1; wa16 = 5'd20; wd16 = 32'hBAD; ra16 = 5'd20;
    @(negedge clk);
    we16 = 1'b0;
    push("d16_drop_oob", 32'h1); pop_cmp({31'h0, drop16});
    push("d16_read_oob", 32'h0); pop_cmp(rd16_a);
    we16 = 1'b1; wa16 = 5'd15; wd16 = 32'h15F; ra16 = 5'd15;
    @(negedge clk);
    we16 = 1'b0;
    push("d16_drop_last", 32'h0); pop_cmp({31'h0, drop16});
    push("d16_read_last", 32'h15F); pop_cmp(rd16_a);

    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
